// File: rtl/mlp_pkg.sv
// Shared definitions for the output-buffer reader.
// Holds the reader FSM state encoding, the default per-word address step
// and the FP32 ordering-key function used by the argmax comparator.
package mlp_pkg;

  localparam int unsigned ADDR_STEP = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Maps an FP32 bit pattern to an unsigned key with the same total order:
  // negatives are inverted (larger magnitude -> smaller key), positives get
  // the sign bit set so they sit above every negative, and +0 lands above -0.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    fp32_key = x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/y_buf_reader_if.sv
// Buffer read port and result stream of the output-buffer reader.
// master: the reader (drives buffer enable/address and the stream).
// slave : buffer + stream sink (drives read data and ready).
//   y_buf_en_o / y_buf_addr_o  buffer read enable and byte address
//   y_buf_data_i               buffer read data, one cycle after enable
//   m_valid_o / m_ready_i      stream handshake
//   m_data_o / m_last_o        stream word and last-word marker
interface y_buf_reader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 6
);

  logic              y_buf_en_o;
  logic [ADDR_W-1:0] y_buf_addr_o;
  logic [DATA_W-1:0] y_buf_data_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DATA_W-1:0] m_data_o;
  logic              m_last_o;

  modport master (
    output y_buf_en_o, y_buf_addr_o, m_valid_o, m_data_o, m_last_o,
    input  y_buf_data_i, m_ready_i
  );

  modport slave (
    input  y_buf_en_o, y_buf_addr_o, m_valid_o, m_data_o, m_last_o,
    output y_buf_data_i, m_ready_i
  );

endinterface

// File: rtl/fp32_key_cmp.sv
// Combinational FP32 "greater than" using the ordering key.
//   a, b   : FP32 bit patterns
//   a_gt_b : 1 when key(a) > key(b) as unsigned
module fp32_key_cmp
  import mlp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic [31:0] w_key_a;
  logic [31:0] w_key_b;

  assign w_key_a = fp32_key(a);
  assign w_key_b = fp32_key(b);
  assign a_gt_b  = (w_key_a > w_key_b);

endmodule

// File: rtl/y_buf_reader.sv
// Drains NUM_CLASS result words from the output buffer onto a valid/ready
// stream while tracking the argmax (lowest index wins ties).
//   clk, rst        : clock, synchronous active-high reset
//   start_i         : one-cycle pulse that starts a drain (ignored when busy)
//   busy_o, done_o  : drain in progress / one-cycle completion pulse
//   class_o         : argmax index, valid while class_valid_o is high
//   bus (master)    : buffer read port and output stream
module y_buf_reader #(
  parameter int unsigned Y_BUF_DATA_WIDTH = 32,
  parameter int unsigned Y_BUF_DEPTH      = 40,
  parameter int unsigned NUM_CLASS        = 10,
  parameter int unsigned ADDR_STEP        = mlp_pkg::ADDR_STEP
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(NUM_CLASS)-1:0] class_o,
  output logic                         class_valid_o,
  y_buf_reader_if.master               bus
);

  import mlp_pkg::state_t, mlp_pkg::ST_IDLE, mlp_pkg::ST_READ,
         mlp_pkg::ST_WAIT, mlp_pkg::ST_SEND, mlp_pkg::ST_DONE;

  localparam int unsigned ADDR_W = $clog2(Y_BUF_DEPTH);
  localparam int unsigned CLS_W  = $clog2(NUM_CLASS);
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);

  state_t r_state;
  state_t w_next_state;

  logic [CLS_W-1:0]            r_idx;
  logic [CLS_W-1:0]            w_next_idx;
  logic [ADDR_W-1:0]           w_next_addr;
  logic                        w_start_acc;
  logic                        w_hs;
  logic                        w_upd_best;
  logic                        w_a_gt_b;
  logic [31:0]                 w_rd_word;

  logic                        r_busy;
  logic                        r_done;
  logic                        r_en;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_valid;
  logic [Y_BUF_DATA_WIDTH-1:0] r_data;
  logic                        r_last;
  logic [CLS_W-1:0]            r_class;
  logic                        r_class_valid;
  logic [31:0]                 r_best;
  logic [CLS_W-1:0]            r_best_idx;

  assign w_rd_word = 32'(bus.y_buf_data_i);

  // Candidate word versus the best seen so far
  fp32_key_cmp u_cmp (
    .a      (w_rd_word),
    .b      (r_best),
    .a_gt_b (w_a_gt_b)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and per-cycle control
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_hs         = 1'b0;
    w_upd_best   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_start_acc  = 1'b1;
          w_next_state = ST_READ;
        end
      end
      ST_READ: w_next_state = ST_WAIT;
      ST_WAIT: begin
        // Word 0 seeds the search; later words need a strictly greater key
        w_upd_best   = (r_idx == '0) || w_a_gt_b;
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        if (bus.m_ready_i) begin
          w_hs         = 1'b1;
          w_next_state = (r_idx == LAST_IDX) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_next_idx = r_idx;
    if (w_start_acc) begin
      w_next_idx = '0;
    end else if (w_hs && (r_idx != LAST_IDX)) begin
      w_next_idx = r_idx + CLS_W'(1);
    end
  end

  assign w_next_addr = ADDR_W'(32'(w_next_idx) * ADDR_STEP);

  // Registered outputs are loaded from the next state so each one is
  // asserted for exactly the cycles the FSM spends in its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_en          <= 1'b0;
      r_addr        <= '0;
      r_valid       <= 1'b0;
      r_data        <= '0;
      r_last        <= 1'b0;
      r_class       <= '0;
      r_class_valid <= 1'b0;
      r_best        <= '0;
      r_best_idx    <= '0;
    end else begin
      r_idx   <= w_next_idx;
      r_busy  <= (w_next_state == ST_READ) || (w_next_state == ST_WAIT) ||
                 (w_next_state == ST_SEND);
      r_done  <= (w_next_state == ST_DONE);
      r_en    <= (w_next_state == ST_READ);
      r_addr  <= (w_next_state == ST_READ) ? w_next_addr : '0;
      r_valid <= (w_next_state == ST_SEND);
      r_last  <= (w_next_state == ST_SEND) && (w_next_idx == LAST_IDX);

      // Buffer data arrives one cycle after the read enable
      if (r_state == ST_WAIT) begin
        r_data <= bus.y_buf_data_i;
      end

      if (w_upd_best) begin
        r_best     <= w_rd_word;
        r_best_idx <= r_idx;
      end

      if (w_start_acc) begin
        r_class_valid <= 1'b0;
      end else if (w_next_state == ST_DONE) begin
        r_class       <= r_best_idx;
        r_class_valid <= 1'b1;
      end
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign class_o          = r_class;
  assign class_valid_o    = r_class_valid;
  assign bus.y_buf_en_o   = r_en;
  assign bus.y_buf_addr_o = r_addr;
  assign bus.m_valid_o    = r_valid;
  assign bus.m_data_o     = r_data;
  assign bus.m_last_o     = r_last;

endmodule
